// File: rtl/alu_exec_unit.sv
// Multi-cycle RV32-style ALU: single-cycle arithmetic/logic ops, shifts iterate one bit per cycle.
// Valid/ready handshake on both sides; flush aborts any in-flight operation.
module alu_exec_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      alu_control,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            illegal
);

  localparam int SHW = $clog2(XLEN);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t          state, state_next;
  logic [1:0]      shift_mode_q;
  logic [SHW-1:0]  cnt_q;
  logic [XLEN-1:0] res_q;
  logic            illegal_q;

  logic            accept;
  logic            is_shift;
  logic [SHW-1:0]  shamt;
  logic [XLEN-1:0] alu_out;
  logic            alu_illegal;

  assign shamt    = op_b[SHW-1:0];
  assign accept   = in_valid && in_ready && !flush;
  assign is_shift = (alu_control == 4'b0001) || (alu_control == 4'b0101) ||
                    (alu_control == 4'b1101);

  // Shift codes land here only with shamt == 0, so they pass op_a through.
  always_comb begin
    alu_out     = '0;
    alu_illegal = 1'b0;
    case (alu_control)
      4'b0000: alu_out = op_a + op_b;
      4'b1000: alu_out = op_a - op_b;
      4'b0001, 4'b0101, 4'b1101: alu_out = op_a;
      4'b0010: alu_out = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      4'b1010: alu_out = {{(XLEN-1){1'b0}}, !($signed(op_a) < $signed(op_b))};
      4'b0011: alu_out = {{(XLEN-1){1'b0}}, (op_a < op_b)};
      4'b1011: alu_out = {{(XLEN-1){1'b0}}, !(op_a < op_b)};
      4'b0100: alu_out = op_a ^ op_b;
      4'b1100: alu_out = {{(XLEN-1){1'b0}}, (op_a == op_b)};
      4'b0110: alu_out = op_a | op_b;
      4'b0111: alu_out = op_a & op_b;
      4'b1001: alu_out = op_a + XLEN'(4);
      default: alu_illegal = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (flush) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:    if (accept) state_next = (is_shift && shamt != '0) ? SHIFT : DONE;
        SHIFT:   if (cnt_q == SHW'(1)) state_next = DONE;
        DONE:    if (out_ready) state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

  // res_q doubles as the shift accumulator; the SRA sign is its own MSB, which never changes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_mode_q <= '0;
      cnt_q        <= '0;
      res_q        <= '0;
      illegal_q    <= 1'b0;
    end else if (!flush) begin
      if (accept) begin
        shift_mode_q <= alu_control[3:2];
        illegal_q    <= alu_illegal;
        if (is_shift && shamt != '0) begin
          res_q <= op_a;
          cnt_q <= shamt;
        end else begin
          res_q <= alu_out;
          cnt_q <= '0;
        end
      end else if (state == SHIFT) begin
        cnt_q <= cnt_q - SHW'(1);
        if (!shift_mode_q[0])     res_q <= res_q << 1;
        else if (shift_mode_q[1]) res_q <= {res_q[XLEN-1], res_q[XLEN-1:1]};
        else                      res_q <= res_q >> 1;
      end
    end
  end

  assign result  = res_q;
  assign zero    = (res_q == '0);
  assign illegal = illegal_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: directed scenarios plus randomized ops
// compared against a plain-arithmetic reference model.
module tb_alu_exec_unit;

  localparam int XLEN = 32;

  logic            clk;
  logic            rst_n;
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [3:0]      alu_control;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            zero;
  logic            illegal;

  int n_cmp = 0;
  int n_err = 0;

  alu_exec_unit #(.XLEN(XLEN)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .alu_control(alu_control),
    .op_a(op_a), .op_b(op_b),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero(zero), .illegal(illegal)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: {illegal, result} straight from the opcode table.
  function automatic logic [XLEN:0] ref_op(input logic [3:0] c, input logic [XLEN-1:0] a,
                                           input logic [XLEN-1:0] b);
    logic signed [XLEN-1:0] sa, sb;
    logic [XLEN-1:0] r;
    int sh;
    sa = a; sb = b; sh = int'(b[4:0]); r = '0;
    case (c)
      4'b0000: r = a + b;
      4'b1000: r = a - b;
      4'b0001: r = a << sh;
      4'b0101: r = a >> sh;
      4'b1101: r = sa >>> sh;
      4'b0010: r = (sa < sb) ? 1 : 0;
      4'b1010: r = (sa < sb) ? 0 : 1;
      4'b0011: r = (a < b) ? 1 : 0;
      4'b1011: r = (a < b) ? 0 : 1;
      4'b0100: r = a ^ b;
      4'b1100: r = (a == b) ? 1 : 0;
      4'b0110: r = a | b;
      4'b0111: r = a & b;
      4'b1001: r = a + 4;
      default: return {1'b1, {XLEN{1'b0}}};
    endcase
    return {1'b0, r};
  endfunction

  function automatic int ref_latency(input logic [3:0] c, input logic [XLEN-1:0] b);
    if ((c == 4'b0001 || c == 4'b0101 || c == 4'b1101) && b[4:0] != 0) return 1 + int'(b[4:0]);
    return 1;
  endfunction

  // Called just after a falling edge; returns just after a falling edge with the block idle.
  task automatic apply_stimulus(input logic [3:0] c, input logic [XLEN-1:0] a,
                                input logic [XLEN-1:0] b, input int hold, input string tag);
    logic [XLEN:0] exp;
    int exp_lat, lat;
    bit seen, busy_ok;
    exp = ref_op(c, a, b);
    exp_lat = ref_latency(c, b);
    in_valid = 1'b1; alu_control = c; op_a = a; op_b = b; out_ready = (hold == 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0; seen = 0; busy_ok = 1;
    for (int i = 1; i <= 80 && !seen; i++) begin
      alu_control = 4'($urandom); op_a = $urandom; op_b = $urandom;
      @(negedge clk);
      lat = i;
      if (out_valid) begin
        seen = 1;
        in_valid = 1'b0;
      end else begin
        if (in_ready) busy_ok = 0;
        in_valid = 1'($urandom_range(0, 1));
      end
    end
    check_output({tag, " latency"}, 64'(lat), 64'(exp_lat));
    check_output({tag, " in_ready busy"}, 64'(busy_ok), 64'd1);
    check_output({tag, " result"}, 64'(result), 64'(exp[XLEN-1:0]));
    check_output({tag, " zero"}, 64'(zero), 64'(exp[XLEN-1:0] == 0));
    check_output({tag, " illegal"}, 64'(illegal), 64'(exp[XLEN]));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); @(negedge clk);
      check_output({tag, " hold valid"}, 64'(out_valid), 64'd1);
      check_output({tag, " hold result"}, 64'({illegal, zero, result}),
                   64'({exp[XLEN], exp[XLEN-1:0] == 0, exp[XLEN-1:0]}));
    end
    out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    out_ready = 1'b0;
    check_output({tag, " valid drop"}, 64'(out_valid), 64'd0);
    check_output({tag, " in_ready back"}, 64'(in_ready), 64'd1);
  endtask

  initial begin
    bit never_valid;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    alu_control = '0; op_a = '0; op_b = '0;
    #2;
    check_output("reset values", 64'({out_valid, in_ready, zero, illegal, result}),
                 64'({4'b0110, 32'h0}));
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);

    apply_stimulus(4'b0000, 32'hFFFF_FFFF, 32'h1, 0, "add wrap");
    apply_stimulus(4'b1101, 32'h8000_0000, 32'h1F, 0, "sra 31");
    apply_stimulus(4'b1100, 32'd5, 32'd5, 0, "eq 5 5");
    apply_stimulus(4'b1100, 32'd5, 32'd6, 1, "eq 5 6");
    apply_stimulus(4'b1010, 32'hFFFF_FFFF, 32'h0, 0, "sge -1 0");
    apply_stimulus(4'b0001, 32'h1, 32'h4, 5, "sll hold");
    apply_stimulus(4'b0001, 32'h1234_5678, 32'h20, 0, "sll shamt0");
    apply_stimulus(4'b1000, 32'h0, 32'h1, 0, "sub wrap");
    apply_stimulus(4'b1001, 32'hFFFF_FFFE, 32'h0, 2, "jmp wrap");

    // Flush on the third cycle of a 20-bit SRL.
    in_valid = 1'b1; alu_control = 4'b0101; op_a = 32'hF000_0000; op_b = 32'd20;
    @(posedge clk); #1; in_valid = 1'b0;
    @(negedge clk); @(negedge clk);
    flush = 1'b1;
    @(posedge clk); @(negedge clk);
    flush = 1'b0;
    check_output("flush idle", 64'({in_ready, out_valid}), 64'b10);
    never_valid = 1;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (out_valid) never_valid = 0;
    end
    check_output("flush no result", 64'(never_valid), 64'd1);

    // Flush coincident with an offered op: nothing is captured.
    flush = 1'b1; in_valid = 1'b1; alu_control = 4'b0000; op_a = 32'd1; op_b = 32'd2;
    @(posedge clk); @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    check_output("flush blocks accept", 64'({in_ready, out_valid}), 64'b10);
    @(posedge clk); @(negedge clk);
    check_output("flush blocks accept later", 64'(out_valid), 64'd0);

    apply_stimulus(4'b1111, 32'h1234, 32'h5678, 1, "illegal 1111");
    apply_stimulus(4'b1110, 32'h0, 32'h0, 0, "illegal 1110");

    // Async reset in the middle of a SHIFT.
    in_valid = 1'b1; alu_control = 4'b0101; op_a = 32'hDEAD_BEEF; op_b = 32'd10;
    @(posedge clk); #1; in_valid = 1'b0;
    @(negedge clk); @(negedge clk); @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_output("async reset", 64'({out_valid, in_ready, zero, illegal, result}),
                 64'({4'b0110, 32'h0}));
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    apply_stimulus(4'b0101, 32'hDEAD_BEEF, 32'd3, 0, "post reset srl");
    apply_stimulus(4'b0110, 32'hF0F0_0000, 32'h0000_0F0F, 0, "post reset or");

    for (int k = 0; k < 40; k++) begin
      logic [3:0] c;
      logic [XLEN-1:0] a, b;
      c = 4'($urandom_range(0, 15));
      a = $urandom;
      b = $urandom;
      if ($urandom_range(0, 3) == 0) b = a;
      apply_stimulus(c, a, b, $urandom_range(0, 3), $sformatf("rand%0d op%b", k, c));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
